// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns each R/W + address + data frame into a single
// register-bank access strobe. All SPI pins are oversampled in the clk_i domain.
module spi_reg_bridge #(
  parameter int ADDR_SIZE = 7
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 sclk_i,
  input  logic                 csn_i,
  input  logic                 mosi_i,
  output logic                 miso_o,
  output logic                 acc_en_o,
  output logic                 wr_en_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [7:0]           wdata_o,
  input  logic [7:0]           rdata_i
);
  localparam int CNT_W = $clog2(ADDR_SIZE + 10);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_SIZE);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(ADDR_SIZE + 8);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t               state_r, state_nxt_s;
  logic                 sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic                 csn_meta_r, csn_sync_r, csn_prev_r;
  logic                 mosi_meta_r, mosi_sync_r;
  logic [1:0]           flush_r;
  logic                 armed_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [ADDR_SIZE-1:0] hdr_shift_r;
  logic [6:0]           data_shift_r;
  logic [7:0]           tx_shift_r;
  logic                 rw_r;
  logic                 sclk_rise_s, sclk_fall_s, csn_rise_s, csn_fall_s;
  logic                 frame_start_s, hdr_bit_s, hdr_done_s;
  logic                 data_bit_s, data_done_s, tx_shift_en_s;
  logic [ADDR_SIZE:0]   hdr_next_s;
  logic [7:0]           data_next_s;

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
  assign csn_rise_s  = csn_sync_r & ~csn_prev_r;
  assign csn_fall_s  = ~csn_sync_r & csn_prev_r;
  assign hdr_next_s  = {hdr_shift_r, mosi_sync_r};
  assign data_next_s = {data_shift_r, mosi_sync_r};

  // Pin synchronizers; armed_r only sets once csn is seen high after reset,
  // so a frame already in progress at reset release is skipped entirely
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      csn_meta_r  <= 1'b1;
      csn_sync_r  <= 1'b1;
      csn_prev_r  <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      flush_r     <= 2'b00;
      armed_r     <= 1'b0;
    end else begin
      sclk_meta_r <= sclk_i;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      csn_meta_r  <= csn_i;
      csn_sync_r  <= csn_meta_r;
      csn_prev_r  <= csn_sync_r;
      mosi_meta_r <= mosi_i;
      mosi_sync_r <= mosi_meta_r;
      flush_r     <= {flush_r[0], 1'b1};
      if (flush_r[1] && csn_sync_r) begin
        armed_r <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle datapath controls
  always_comb begin
    state_nxt_s   = state_r;
    frame_start_s = 1'b0;
    hdr_bit_s     = 1'b0;
    hdr_done_s    = 1'b0;
    data_bit_s    = 1'b0;
    data_done_s   = 1'b0;
    tx_shift_en_s = 1'b0;
    if (csn_rise_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (csn_fall_s && armed_r) begin
            state_nxt_s   = HDR;
            frame_start_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        HDR: begin
          if (sclk_rise_s) begin
            hdr_bit_s = 1'b1;
            if (bit_cnt_r == HDR_LAST) begin
              hdr_done_s  = 1'b1;
              state_nxt_s = DATA;
            end else begin
              state_nxt_s = HDR;
            end
          end else begin
            state_nxt_s = HDR;
          end
        end
        DATA: begin
          if (sclk_rise_s) begin
            data_bit_s = 1'b1;
            if (bit_cnt_r == DATA_LAST) begin
              data_done_s = 1'b1;
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = DATA;
            end
          end else if (sclk_fall_s) begin
            tx_shift_en_s = 1'b1;
          end else begin
            state_nxt_s = DATA;
          end
        end
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Frame datapath and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bit_cnt_r    <= {CNT_W{1'b0}};
      hdr_shift_r  <= {ADDR_SIZE{1'b0}};
      data_shift_r <= 7'h00;
      tx_shift_r   <= 8'h00;
      rw_r         <= 1'b0;
      addr_o       <= {ADDR_SIZE{1'b0}};
      wdata_o      <= 8'h00;
      acc_en_o     <= 1'b0;
      wr_en_o      <= 1'b0;
      miso_o       <= 1'b0;
    end else begin
      acc_en_o <= 1'b0;
      wr_en_o  <= 1'b0;
      if (frame_start_s) begin
        bit_cnt_r    <= {CNT_W{1'b0}};
        hdr_shift_r  <= {ADDR_SIZE{1'b0}};
        data_shift_r <= 7'h00;
      end else if (hdr_bit_s) begin
        bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
        hdr_shift_r <= hdr_next_s[ADDR_SIZE-1:0];
      end else if (data_bit_s) begin
        bit_cnt_r    <= bit_cnt_r + CNT_W'(1);
        data_shift_r <= data_next_s[6:0];
      end
      // Reads are issued as soon as the header is known, writes after the data byte
      if (hdr_done_s) begin
        addr_o   <= hdr_next_s[ADDR_SIZE-1:0];
        rw_r     <= hdr_next_s[ADDR_SIZE];
        acc_en_o <= ~hdr_next_s[ADDR_SIZE];
      end
      if (data_done_s && rw_r) begin
        wdata_o  <= data_next_s;
        acc_en_o <= 1'b1;
        wr_en_o  <= 1'b1;
      end
      if (frame_start_s) begin
        tx_shift_r <= 8'h00;
      end else if (acc_en_o && !wr_en_o) begin
        tx_shift_r <= rdata_i;
      end else if (tx_shift_en_s) begin
        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
      end
      if (csn_rise_s || frame_start_s || data_done_s) begin
        miso_o <= 1'b0;
      end else if (tx_shift_en_s) begin
        miso_o <= tx_shift_r[7];
      end
    end
  end
endmodule
